// File: rtl/waveform_pkg.sv
// ============================================================================
//  Module      : waveform_pkg
//  Description : Shared state encoding and register map for the SDRAM
//                waveform player/recorder pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package waveform_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic REG_LENGTH = 1'b0;
    localparam logic REG_CTRL   = 1'b1;

    localparam int CTRL_START_BIT = 0;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_DROP_LSB  = 16;
    localparam int DROP_W         = 16;

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
//  Module      : sample_fifo
//  Description : Synchronous staging FIFO with flush and a registered head
//                output so the consumer never sees a same-cycle push.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = head_q;

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (push_ok) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // Incoming data becomes the head when nothing older survives this cycle.
        if (push_ok && (empty_o || (pop_ok && cnt_q == CNT_W'(1)))) begin
            head_d = data_i;
        end else if (pop_ok) begin
            head_d = mem_q[rd_q + PTR_W'(1)];
        end
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/waveform_recorder.sv
// ============================================================================
//  Module      : waveform_recorder
//  Description : Streams Avalon-ST audio samples into SDRAM from word 0 via a
//                staging FIFO; CPU control/status through a 2-word slave.
//                Optional drop counter: WAVEFORM_RECORDER_OVERFLOW_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module waveform_recorder
    import waveform_pkg::*;
#(
    parameter int ADDR_W     = 26,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [1:0]        sdram_byteenable_n,
    output logic              sdram_chipselect,
    output logic [15:0]       sdram_writedata,
    output logic              sdram_read_n,
    output logic              sdram_write_n,
    input  logic              sdram_waitrequest,
    input  logic [15:0]       audio_data,
    input  logic              audio_valid,
    output logic              audio_ready
);

    state_e      state_q, state_d;
    logic [31:0] length_q, length_d;
    logic [31:0] accepted_q, accepted_d;
    logic [31:0] written_q, written_d;
    logic        done_q, done_d;
    logic [31:0] readdata_q, readdata_d;
    logic [31:0] status;

    logic        capturing;
    logic        ctrl_wr;
    logic        arm;
    logic        abort;
    logic        push;
    logic        pop;
    logic        write_req;
    logic        fifo_flush;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_head;

    assign capturing = (state_q == CAPTURE);
    assign ctrl_wr   = write && (address == REG_CTRL);
    assign arm       = ctrl_wr && writedata[CTRL_START_BIT] && !capturing;
    assign abort     = ctrl_wr && !writedata[CTRL_START_BIT];

    assign audio_ready = capturing && !fifo_full && (accepted_q < length_q);
    assign push        = audio_valid && audio_ready;
    assign write_req   = capturing && !fifo_empty;
    assign pop         = write_req && !sdram_waitrequest;

    assign sdram_addr         = written_q[ADDR_W-1:0];
    assign sdram_writedata    = fifo_head;
    assign sdram_chipselect   = write_req;
    assign sdram_write_n      = !write_req;
    assign sdram_byteenable_n = 2'b00;
    assign sdram_read_n       = 1'b1;
    assign readdata           = readdata_q;

    sample_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .flush_i   (fifo_flush),
        .push_i    (push),
        .data_i    (audio_data),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head)
    );

`ifdef WAVEFORM_RECORDER_OVERFLOW_EN
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (capturing && audio_valid && !audio_ready && (accepted_q < length_q)) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
        if (arm) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end
`endif

    always_comb begin
        status                = '0;
        status[STAT_BUSY_BIT] = capturing;
        status[STAT_DONE_BIT] = done_q;
`ifdef WAVEFORM_RECORDER_OVERFLOW_EN
        status[STAT_OVF_BIT]                   = ovf_q;
        status[STAT_DROP_LSB +: DROP_W]        = drop_q;
`else
        status[STAT_OVF_BIT]                   = 1'b0;
        status[STAT_DROP_LSB +: DROP_W]        = '0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        accepted_d = accepted_q;
        written_d  = written_q;
        done_d     = done_q;
        readdata_d = readdata_q;
        fifo_flush = 1'b0;

        if (push) begin
            accepted_d = accepted_q + 32'd1;
        end
        if (pop) begin
            written_d = written_q + 32'd1;
        end
        if (write && (address == REG_LENGTH)) begin
            length_d = writedata;
        end
        if (read) begin
            readdata_d = (address == REG_LENGTH) ? written_q : status;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    accepted_d = '0;
                    written_d  = '0;
                    fifo_flush = 1'b1;
                    if (length_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                        done_d  = 1'b0;
                    end
                end
            end
            CAPTURE: begin
                if ((written_q == length_q) && fifo_empty) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over completion; any pending SDRAM request is withdrawn.
        if (abort) begin
            state_d    = IDLE;
            done_d     = 1'b0;
            fifo_flush = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            length_q   <= '0;
            accepted_q <= '0;
            written_q  <= '0;
            done_q     <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            accepted_q <= accepted_d;
            written_q  <= written_d;
            done_q     <= done_d;
            readdata_q <= readdata_d;
        end
    end

endmodule

`default_nettype wire
